// File: rtl/score_pkg.sv
// Shared types for the Simon Says score counter: BCD digit type and blink FSM states.
package score_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    typedef enum logic [1:0] {SHOW, BLINK_ON, BLINK_OFF} blink_state_t;

    function automatic bcd_t bcd_inc(input bcd_t d);
        return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/score_bcd_counter_digit.sv
// One decimal digit of the score chain; carries into the next digit when it rolls 9 -> 0.
module bcd_digit
    import score_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc_in,
    output bcd_t digit,
    output logic carry_out
);

    bcd_t r_digit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= '0;
        end else if (clr) begin
            r_digit <= '0;
        end else if (inc_in) begin
            r_digit <= bcd_inc(r_digit);
        end
    end

    assign digit     = r_digit;
    assign carry_out = inc_in & (r_digit == BCD_MAX);

endmodule

// File: rtl/score_bcd_counter.sv
// Simon Says score/high-score BCD counter with leading-zero blanking and registered outputs.
// Optional new-high-score blinking is built when the macro SCORE_BLINK_EN is defined.
module score_bcd_counter
    import score_pkg::*;
#(
    parameter int NUM_DIGITS     = 2,
    parameter int BLINK_HALF_CYC = 25_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    inc,
    input  logic                    clr,
    input  logic                    show_high,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    score_sat,
    output logic                    new_high
);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 4) begin : g_badDigits
        $error("score_bcd_counter: NUM_DIGITS must be 1..4");
    end
    if (BLINK_HALF_CYC < 1) begin : g_badBlink
        $error("score_bcd_counter: BLINK_HALF_CYC must be at least 1");
    end

    logic [4*NUM_DIGITS-1:0] w_score;
    logic [NUM_DIGITS:0]     w_carry;
    logic                    w_allNines;
    logic                    w_highUpdate;
    logic [4*NUM_DIGITS-1:0] w_sel;
    logic [NUM_DIGITS-1:0]   w_mask;
    logic                    w_blankAll;

    logic [4*NUM_DIGITS-1:0] r_high;
    logic                    r_newHighPend;
    logic                    r_newHigh;
    logic                    r_scoreSat;
    logic [4*NUM_DIGITS-1:0] r_hex;
    logic [NUM_DIGITS-1:0]   r_digEn;

    // Saturation gating uses the live score so back-to-back pulses at 99 never wrap.
    always_comb begin
        w_allNines = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_allNines = w_allNines & (w_score[4*i +: 4] == BCD_MAX);
        end
    end

    assign w_carry[0] = inc & ~w_allNines;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (clr),
            .inc_in    (w_carry[g]),
            .digit     (w_score[4*g +: 4]),
            .carry_out (w_carry[g+1])
        );
    end

    assert property (@(posedge clk) disable iff (!rst_n) !w_carry[NUM_DIGITS]);

    // Packed BCD keeps decimal ordering, so a plain unsigned compare is MS-digit-first.
    assign w_highUpdate = (w_score > r_high);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_high        <= '0;
            r_newHighPend <= 1'b0;
        end else begin
            if (w_highUpdate) begin
                r_high <= w_score;
            end
            if (clr) begin
                r_newHighPend <= 1'b0;
            end else if (w_highUpdate) begin
                r_newHighPend <= 1'b1;
            end
        end
    end

    assign w_sel = show_high ? r_high : w_score;

    always_comb begin
        logic anyNonZero;
        anyNonZero = 1'b0;
        w_mask     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            anyNonZero = anyNonZero | (w_sel[4*i +: 4] != 4'd0);
            w_mask[i]  = anyNonZero;
        end
        w_mask[0] = 1'b1;
    end

`ifdef SCORE_BLINK_EN
    localparam int CW = $clog2(BLINK_HALF_CYC + 1);

    blink_state_t r_state;
    blink_state_t w_nextState;
    logic [CW-1:0] r_blinkCnt;
    logic          r_newHighDly;
    logic          w_newHighRise;
    logic          w_halfDone;

    assign w_newHighRise = r_newHigh & ~r_newHighDly;
    assign w_halfDone    = (r_blinkCnt == CW'(BLINK_HALF_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= SHOW;
            r_blinkCnt   <= '0;
            r_newHighDly <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_newHighDly <= r_newHigh;
            if (w_nextState == SHOW || w_nextState != r_state) begin
                r_blinkCnt <= '0;
            end else begin
                r_blinkCnt <= r_blinkCnt + CW'(1);
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (clr || show_high) begin
            w_nextState = SHOW;
        end else begin
            case (r_state)
                SHOW:      if (w_newHighRise) w_nextState = BLINK_ON;
                BLINK_ON:  if (w_halfDone)    w_nextState = BLINK_OFF;
                BLINK_OFF: if (w_halfDone)    w_nextState = BLINK_ON;
                default:   w_nextState = SHOW;
            endcase
        end
    end

    always_comb begin
        w_blankAll = (r_state == BLINK_OFF);
    end
`else
    assign w_blankAll = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hex      <= '0;
            r_digEn    <= {{(NUM_DIGITS-1){1'b0}}, 1'b1};
            r_scoreSat <= 1'b0;
            r_newHigh  <= 1'b0;
        end else begin
            r_hex      <= w_sel;
            r_digEn    <= w_blankAll ? '0 : w_mask;
            r_scoreSat <= w_allNines;
            r_newHigh  <= clr ? 1'b0 : r_newHighPend;
        end
    end

    assign hex_out   = r_hex;
    assign dig_en    = r_digEn;
    assign score_sat = r_scoreSat;
    assign new_high  = r_newHigh;

endmodule
